// File: rtl/shell_pkg.sv
// Shared types and helpers for the shell pool: direction and fire-FSM encodings,
// default map size, and a cell-stepping helper used for both spawn and flight.
package shell_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        COOL = 2'd2
    } fire_state_t;

    localparam int DEF_MAP_W = 40;
    localparam int DEF_MAP_H = 30;

    // Signed arithmetic so a step off the low edge shows up as -1, not a wrap.
    function automatic logic step_cell(input int x, input int y, input dir_t d,
                                       input int map_w, input int map_h,
                                       output int nx, output int ny);
        nx = x;
        ny = y;
        case (d)
            UP:    ny = y - 1;
            DOWN:  ny = y + 1;
            LEFT:  nx = x - 1;
            RIGHT: nx = x + 1;
            default: ;
        endcase
        return (nx >= 0) && (nx < map_w) && (ny >= 0) && (ny < map_h);
    endfunction

endpackage

// File: rtl/shell_slot.sv
// One shell slot: holds position, direction and valid, and applies
// allocation, per-frame flight, edge-of-map removal and vanish.
module shell_slot
    import shell_pkg::*;
#(
    parameter int POS_W = 6,
    parameter int MAP_W = DEF_MAP_W,
    parameter int MAP_H = DEF_MAP_H
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame,
    input  logic             alloc,
    input  logic [POS_W-1:0] alloc_x,
    input  logic [POS_W-1:0] alloc_y,
    input  logic [1:0]       alloc_dir,
    input  logic             vanish,
    output logic [POS_W-1:0] x,
    output logic [POS_W-1:0] y,
    output logic [1:0]       dir,
    output logic             valid,
    output logic             valid_d
);

    int   nx;
    int   ny;
    logic step_ok;

    always_comb begin
        nx      = 0;
        ny      = 0;
        step_ok = step_cell(int'(x), int'(y), dir_t'(dir), MAP_W, MAP_H, nx, ny);
    end

    // Vanish wins over everything, then a fresh allocation, then flight.
    always_comb begin
        valid_d = valid;
        if (vanish)
            valid_d = 1'b0;
        else if (alloc)
            valid_d = 1'b1;
        else if (frame && valid && !step_ok)
            valid_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            x     <= '0;
            y     <= '0;
            dir   <= '0;
        end else begin
            valid <= valid_d;
            if (!vanish) begin
                if (alloc) begin
                    x   <= alloc_x;
                    y   <= alloc_y;
                    dir <= alloc_dir;
                end else if (frame && valid && step_ok) begin
                    x <= POS_W'(nx);
                    y <= POS_W'(ny);
                end
            end
        end
    end

endmodule

// File: rtl/shell_pool.sv
// Per-player shell pool with fire FSMs and slot allocation.
// Optional per-player fire cooldown enabled by defining SHELL_COOLDOWN_EN.
module shell_pool
    import shell_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int NUM_SHELLS  = 5,
    parameter int POS_W       = 6,
    parameter int MAP_W       = DEF_MAP_W,
    parameter int MAP_H       = DEF_MAP_H,
    parameter int COOLDOWN    = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  i_frame,
    input  logic [NUM_PLAYERS-1:0]                i_fire,
    input  logic [NUM_PLAYERS*POS_W-1:0]          i_tank_x,
    input  logic [NUM_PLAYERS*POS_W-1:0]          i_tank_y,
    input  logic [NUM_PLAYERS*2-1:0]              i_tank_dir,
    input  logic [NUM_PLAYERS*NUM_SHELLS-1:0]     i_vanish,
    output logic [NUM_PLAYERS*NUM_SHELLS*POS_W-1:0] o_shell_x,
    output logic [NUM_PLAYERS*NUM_SHELLS*POS_W-1:0] o_shell_y,
    output logic [NUM_PLAYERS*NUM_SHELLS*2-1:0]     o_shell_dir,
    output logic [NUM_PLAYERS*NUM_SHELLS-1:0]     o_valid,
    output logic [NUM_PLAYERS-1:0]                o_fire_ack,
    output logic [NUM_PLAYERS-1:0]                o_full
);

`ifdef SHELL_COOLDOWN_EN
    localparam int CNT_W = $clog2(COOLDOWN + 2);
`endif

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        fire_state_t           state;
        logic                  ack;
        logic                  full;
        int                    sx;
        int                    sy;
        logic                  spawn_ok;
        logic                  alloc_en;
        logic [POS_W-1:0]      spawn_x;
        logic [POS_W-1:0]      spawn_y;
        logic [NUM_SHELLS-1:0] free;
        logic [NUM_SHELLS-1:0] pick;
        logic [NUM_SHELLS-1:0] alloc;
        logic [NUM_SHELLS-1:0] valid_d;
`ifdef SHELL_COOLDOWN_EN
        logic [CNT_W-1:0]      cnt;
`endif

        // Free slots use start-of-cycle validity; a slot vanishing now is not reused.
        always_comb begin
            sx       = 0;
            sy       = 0;
            spawn_ok = step_cell(int'(i_tank_x[p*POS_W +: POS_W]),
                                 int'(i_tank_y[p*POS_W +: POS_W]),
                                 dir_t'(i_tank_dir[p*2 +: 2]), MAP_W, MAP_H, sx, sy);
            spawn_x  = POS_W'(sx);
            spawn_y  = POS_W'(sy);
            free     = ~o_valid[p*NUM_SHELLS +: NUM_SHELLS] & ~i_vanish[p*NUM_SHELLS +: NUM_SHELLS];
            pick     = free & (~free + 1'b1);
            alloc_en = i_frame && (state == PEND) && spawn_ok && (free != '0);
            alloc    = alloc_en ? pick : '0;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state <= IDLE;
                ack   <= 1'b0;
`ifdef SHELL_COOLDOWN_EN
                cnt   <= '0;
`endif
            end else begin
                ack <= 1'b0;
                case (state)
                    IDLE: if (i_fire[p]) state <= PEND;
                    PEND: begin
                        if (i_frame) begin
                            ack <= alloc_en;
`ifdef SHELL_COOLDOWN_EN
                            state <= COOL;
                            cnt   <= CNT_W'(COOLDOWN);
`else
                            state <= IDLE;
`endif
                        end
                    end
`ifdef SHELL_COOLDOWN_EN
                    COOL: begin
                        if (i_frame) begin
                            if (cnt <= CNT_W'(1)) begin
                                state <= IDLE;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt - 1'b1;
                            end
                        end
                    end
`endif
                    default: state <= IDLE;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (rst) full <= 1'b0;
            else     full <= &valid_d;
        end

        assign o_fire_ack[p] = ack;
        assign o_full[p]     = full;

        for (genvar s = 0; s < NUM_SHELLS; s++) begin : g_slot
            localparam int K = p*NUM_SHELLS + s;
            shell_slot #(
                .POS_W (POS_W),
                .MAP_W (MAP_W),
                .MAP_H (MAP_H)
            ) u_slot (
                .clk       (clk),
                .rst       (rst),
                .frame     (i_frame),
                .alloc     (alloc[s]),
                .alloc_x   (spawn_x),
                .alloc_y   (spawn_y),
                .alloc_dir (i_tank_dir[p*2 +: 2]),
                .vanish    (i_vanish[K]),
                .x         (o_shell_x[K*POS_W +: POS_W]),
                .y         (o_shell_y[K*POS_W +: POS_W]),
                .dir       (o_shell_dir[K*2 +: 2]),
                .valid     (o_valid[K]),
                .valid_d   (valid_d[s])
            );
        end
    end

endmodule

// File: tb/tb_shell_pool.sv
// Directed bench for shell_pool with a reference model of every slot and an
// ack scoreboard fed at each frame and drained one cycle later.
module tb_shell_pool;

    localparam int NP = 2;
    localparam int NS = 5;
    localparam int PW = 6;
    localparam int NK = NP*NS;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              i_frame = 1'b0;
    logic [NP-1:0]     i_fire = '0;
    logic [NP*PW-1:0]  i_tank_x = '0;
    logic [NP*PW-1:0]  i_tank_y = '0;
    logic [NP*2-1:0]   i_tank_dir = '0;
    logic [NK-1:0]     i_vanish = '0;
    logic [NK*PW-1:0]  o_shell_x;
    logic [NK*PW-1:0]  o_shell_y;
    logic [NK*2-1:0]   o_shell_dir;
    logic [NK-1:0]     o_valid;
    logic [NP-1:0]     o_fire_ack;
    logic [NP-1:0]     o_full;

    int tests = 0;
    int fails = 0;

    bit mv [NK];
    int mx [NK];
    int my [NK];
    int md [NK];
    bit pend [NP];
    int tx [NP];
    int ty [NP];
    int td [NP];
    logic [NP-1:0] ack_q [$];

    shell_pool #(
        .NUM_PLAYERS (NP),
        .NUM_SHELLS  (NS),
        .POS_W       (PW),
        .MAP_W       (40),
        .MAP_H       (30),
        .COOLDOWN    (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_frame     (i_frame),
        .i_fire      (i_fire),
        .i_tank_x    (i_tank_x),
        .i_tank_y    (i_tank_y),
        .i_tank_dir  (i_tank_dir),
        .i_vanish    (i_vanish),
        .o_shell_x   (o_shell_x),
        .o_shell_y   (o_shell_y),
        .o_shell_dir (o_shell_dir),
        .o_valid     (o_valid),
        .o_fire_ack  (o_fire_ack),
        .o_full      (o_full)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Next cell for a 40x30 map; returns 0 when the step leaves the map.
    function automatic bit ref_step(input int x, input int y, input int d,
                                    output int nx, output int ny);
        nx = x;
        ny = y;
        if (d == 0) ny = y - 1;
        else if (d == 1) ny = y + 1;
        else if (d == 2) nx = x - 1;
        else nx = x + 1;
        return (nx >= 0 && nx <= 39 && ny >= 0 && ny <= 29);
    endfunction

    task automatic set_tank(input int p, input int x, input int y, input int d);
        tx[p] = x; ty[p] = y; td[p] = d;
        i_tank_x[p*PW +: PW] = PW'(x);
        i_tank_y[p*PW +: PW] = PW'(y);
        i_tank_dir[p*2 +: 2] = 2'(d);
    endtask

    task automatic fire(input int p);
        i_fire[p] = 1'b1;
        tick();
        i_fire[p] = 1'b0;
        pend[p] = 1'b1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < NK; k++) mv[k] = 1'b0;
        for (int p = 0; p < NP; p++) pend[p] = 1'b0;
        ack_q.delete();
    endtask

    task automatic check_all(input string tag);
        logic [NK-1:0] ev;
        logic [NP-1:0] ef;
        for (int k = 0; k < NK; k++) ev[k] = mv[k];
        for (int p = 0; p < NP; p++) begin
            ef[p] = 1'b1;
            for (int s = 0; s < NS; s++) if (!mv[p*NS+s]) ef[p] = 1'b0;
        end
        chk({tag, ".valid"}, 64'(o_valid), 64'(ev));
        chk({tag, ".full"}, 64'(o_full), 64'(ef));
        for (int k = 0; k < NK; k++) begin
            if (mv[k]) begin
                chk($sformatf("%s.x%0d", tag, k), 64'(o_shell_x[k*PW +: PW]), 64'(mx[k]));
                chk($sformatf("%s.y%0d", tag, k), 64'(o_shell_y[k*PW +: PW]), 64'(my[k]));
                chk($sformatf("%s.d%0d", tag, k), 64'(o_shell_dir[k*2 +: 2]), 64'(md[k]));
            end
        end
    endtask

    task automatic frame(input string tag, input logic [NK-1:0] van);
        bit            sv [NK];
        bit            al [NK];
        int            nx, ny;
        bit            ok, found;
        logic [NP-1:0] ack;
        logic [NP-1:0] got;
        for (int k = 0; k < NK; k++) begin sv[k] = mv[k]; al[k] = 1'b0; end
        for (int p = 0; p < NP; p++) begin
            ack[p] = 1'b0;
            if (pend[p]) begin
                ok = ref_step(tx[p], ty[p], td[p], nx, ny);
                found = 1'b0;
                for (int s = 0; s < NS; s++) begin
                    if (ok && !found && !sv[p*NS+s] && !van[p*NS+s]) begin
                        found = 1'b1;
                        al[p*NS+s] = 1'b1;
                        mx[p*NS+s] = nx; my[p*NS+s] = ny; md[p*NS+s] = td[p];
                        ack[p] = 1'b1;
                    end
                end
            end
            pend[p] = 1'b0;
        end
        for (int k = 0; k < NK; k++) begin
            if (van[k]) mv[k] = 1'b0;
            else if (al[k]) mv[k] = 1'b1;
            else if (sv[k]) begin
                if (ref_step(mx[k], my[k], md[k], nx, ny)) begin mx[k] = nx; my[k] = ny; end
                else mv[k] = 1'b0;
            end
        end
        ack_q.push_back(ack);
        i_frame  = 1'b1;
        i_vanish = van;
        tick();
        i_frame  = 1'b0;
        i_vanish = '0;
        got = ack_q.pop_front();
        chk({tag, ".ack"}, 64'(o_fire_ack), 64'(got));
        check_all(tag);
        tick();
        chk({tag, ".ack_pulse"}, 64'(o_fire_ack), 64'(0));
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_all("reset");
        chk("reset.ack", 64'(o_fire_ack), 64'(0));
        chk("reset.x", 64'(o_shell_x), 64'(0));

`ifndef SHELL_COOLDOWN_EN
        // Basic spawn and flight
        set_tank(0, 10, 10, 3);
        set_tank(1, 20, 20, 0);
        fire(0);
        frame("spawn", '0);
        chk("spawn.slot0", {o_valid[0], 2'b00, o_shell_x[5:0], 2'b00, o_shell_y[5:0]},
            {1'b1, 2'b00, 6'd11, 2'b00, 6'd10});
        frame("fly", '0);

        // Edge removal at high and low borders
        set_tank(0, 38, 5, 3);
        set_tank(1, 1, 3, 2);
        fire(0);
        fire(1);
        frame("edge_spawn", '0);
        frame("edge_exit", '0);
        chk("edge.nowrap_x", 64'(o_shell_x[5*PW +: PW]), 64'(0));

        // Spawn cell off the map is refused
        set_tank(0, 39, 5, 3);
        fire(0);
        frame("offmap", '0);

        // Six consecutive fires fill player 1
        set_tank(1, 20, 20, 0);
        for (int f = 0; f < 6; f++) begin
            fire(1);
            frame($sformatf("fill%0d", f), '0);
        end
        chk("fill.full1", 64'(o_full[1]), 64'(1));

        // Vanish in a frame cycle frees the slot only for the next frame
        fire(1);
        frame("vanish", 10'b00_1000_0000);
        fire(1);
        frame("reuse", '0);

        // Reset during a frame with a pending fire
        set_tank(0, 10, 10, 1);
        fire(0);
        rst = 1'b1;
        i_frame = 1'b1;
        tick();
        rst = 1'b0;
        i_frame = 1'b0;
        model_reset();
        check_all("rstmid");
        chk("rstmid.ack", 64'(o_fire_ack), 64'(0));
        chk("rstmid.pos", 64'({o_shell_x, o_shell_y}), 64'(0));
        chk("rstmid.dir", 64'(o_shell_dir), 64'(0));
        frame("rst_nofire", '0);
        fire(0);
        frame("rst_refire", '0);
`else
        // Held fire with cooldown: one shot every five frames
        set_tank(0, 0, 10, 3);
        i_fire[0] = 1'b1;
        tick();
        for (int f = 0; f < 15; f++) begin
            logic [NP-1:0] got;
            ack_q.push_back((f % 5 == 0) ? 2'b01 : 2'b00);
            i_frame = 1'b1;
            tick();
            i_frame = 1'b0;
            got = ack_q.pop_front();
            chk($sformatf("cool%0d.ack", f), 64'(o_fire_ack), 64'(got));
            tick();
            tick();
        end
        i_fire[0] = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/shell_pool.md
SHELL_POOL -- requirements
Module: shell_pool

Interface
REQ-001 SHALL have parameter NUM_PLAYERS, default 2, number of tanks owning shells.
REQ-002 SHALL have parameter NUM_SHELLS, default 5, shell slots per player.
REQ-003 SHALL have parameters POS_W, MAP_W, MAP_H, defaults 6, 40, 30: coordinate width and map size in cells.
REQ-004 SHALL have parameter COOLDOWN, default 4, frames between shots per player (used only under REQ-025).
REQ-005 SHALL have ports, clock and reset first: clk in 1 system clock; rst in 1 reset, synchronous, active-high.
REQ-006 SHALL have i_frame in 1: one-cycle game-frame tick.
REQ-007 SHALL have i_fire in NUM_PLAYERS: fire request, level or pulse, one per player.
REQ-008 SHALL have i_tank_x, i_tank_y in NUM_PLAYERS*POS_W each, and i_tank_dir in NUM_PLAYERS*2: tank cell and direction (0 up, 1 down, 2 left, 3 right).
REQ-009 SHALL have i_vanish in NUM_PLAYERS*NUM_SHELLS: per-slot kill from collision logic.
REQ-010 SHALL have outputs o_shell_x, o_shell_y (NUM_PLAYERS*NUM_SHELLS*POS_W each), o_shell_dir (NUM_PLAYERS*NUM_SHELLS*2), o_valid (NUM_PLAYERS*NUM_SHELLS), o_fire_ack (NUM_PLAYERS, one-cycle pulse), o_full (NUM_PLAYERS). Slot s of player p is at flat index p*NUM_SHELLS+s.

Function
REQ-011 SHALL run a per-player fire FSM with states IDLE, PEND, COOL.
REQ-012 IDLE -> PEND on i_fire=1 in a cycle without i_frame, or in an i_frame cycle (the fire is then served at the next frame); PEND holds until i_frame.
REQ-013 On i_frame in PEND: allocate the lowest-index slot with o_valid=0, at the start of that cycle, to that player; pulse o_fire_ack next cycle; go to COOL (macro on) or IDLE (macro off).
REQ-014 New shell position = tank cell stepped one cell in i_tank_dir, sampled in the i_frame cycle; o_shell_dir = i_tank_dir.
REQ-015 If the spawn cell is outside [0,MAP_W-1]x[0,MAP_H-1], or no slot is free: no allocation, no ack, FSM still leaves PEND.
REQ-016 On i_frame, every valid shell not allocated that frame moves one cell in its direction: up y-1, down y+1, left x-1, right x+1.
REQ-017 A shell whose next cell would leave the map clears o_valid instead of moving; coordinates never wrap.
REQ-018 i_vanish[k]=1 in any cycle clears o_valid[k] next cycle; in an i_frame cycle vanish beats step for slot k.
REQ-019 A slot vanished in an i_frame cycle is not reusable in that same frame (REQ-013 uses start-of-cycle validity).
REQ-020 o_full[p]=1 iff all NUM_SHELLS slots of player p are valid; registered, same cycle as o_valid.
REQ-021 All outputs are registered; latency from i_frame to updated positions/valid is 1 cycle.
REQ-022 Players are independent; simultaneous fires from all players in one frame are all served.

Reset
REQ-023 rst=1 at a rising clk edge SHALL clear o_valid, o_shell_x/y/dir, o_fire_ack, o_full, cooldown counters, and return all FSMs to IDLE; rst beats i_frame, i_fire and i_vanish in the same cycle.
REQ-024 Pending fires SHALL be discarded by reset mid-operation; the first allocation after reset needs a fresh i_fire.

Configuration
REQ-025 Macro SHELL_COOLDOWN_EN defined: COOL state loads counter with COOLDOWN, decrements on each i_frame, returns to IDLE at 0, ignores i_fire while in COOL.
REQ-026 SHELL_COOLDOWN_EN undefined: no COOL state or counter; player may fire every frame.

Structure
REQ-027 Shared package shell_pkg SHALL hold dir_t (UP=0, DOWN=1, LEFT=2, RIGHT=3), fire FSM state enum, and default MAP_W/MAP_H constants.
REQ-028 Sub-module shell_slot SHALL hold one slot (position, direction, valid, step/bound/vanish logic), instantiated NUM_PLAYERS*NUM_SHELLS times.

Verification
REQ-029 Tank0 at (10,10) dir RIGHT, i_fire pulse, then i_frame -> slot 0 valid at (11,10), o_fire_ack[0] pulse; next i_frame -> (12,10).
REQ-030 Shell at (39,5) RIGHT, i_frame -> o_valid cleared; shell at (0,3) LEFT, i_frame -> cleared, x never becomes 63.
REQ-031 Player 1 fires on 6 consecutive frames (macro off, NUM_SHELLS=5) -> slots 0-4 filled, o_full[1]=1, sixth fire gives no ack.
REQ-032 i_vanish on slot 2 in the same cycle as i_frame with all slots full and pending fire -> slot 2 cleared, no allocation that frame; allocated to slot 2 at next frame after a new fire.
REQ-033 Macro on, COOLDOWN=4, fire held high -> acks exactly every 5 frames.
REQ-034 rst asserted in an i_frame cycle with 3 valid shells and a pending fire -> all outputs 0 next cycle, no ack until a new i_fire and i_frame.
